// File: rtl/integral_image_writer.sv
// Streams raster pixels into an integral-image BRAM, one summed word written per accepted pixel.
// Optional INTEGRAL_SAT_EN: adders saturate at all-ones instead of wrapping.
module integral_image_writer #(
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int PIX_W      = 8,
  parameter int DATA_WIDTH = 22,
  parameter int ADDR_W     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic                  we,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  function automatic logic [DATA_WIDTH-1:0] add_sat(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef INTEGRAL_SAT_EN
    return s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
`else
    return s[DATA_WIDTH-1:0];
`endif
  endfunction

  state_t                  state_q;
  logic [CW-1:0]           col_q;
  logic [RW-1:0]           row_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]   row_sum_q;
  logic                    pix_ready_q, we_q, done_q, err_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [DATA_WIDTH-1:0]   lb [IMG_W];

  logic                    accept, process, last_px;
  logic [CW-1:0]           col_d;
  logic [RW-1:0]           row_d;
  logic [ADDR_W-1:0]       addr_d;
  logic [DATA_WIDTH-1:0]   rs_d, above_d, sum_d;

  // A sof pixel always restarts at (0,0), whether the block was idle or mid-frame.
  always_comb begin
    accept  = pix_valid & pix_ready_q;
    process = accept & (pix_sof | (state_q == S_ACTIVE));
    col_d   = pix_sof ? '0 : col_q;
    row_d   = pix_sof ? '0 : row_q;
    addr_d  = pix_sof ? '0 : addr_q;
    rs_d    = add_sat((col_d == '0) ? '0 : row_sum_q, DATA_WIDTH'(pix_data));
    above_d = (row_d == '0) ? '0 : lb[col_d];
    sum_d   = add_sat(rs_d, above_d);
    last_px = (col_d == COL_LAST) && (row_d == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      row_sum_q   <= '0;
      pix_ready_q <= 1'b0;
      we_q        <= 1'b0;
      wr_addr_q   <= '0;
      din_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      we_q   <= process;
      done_q <= 1'b0;
      err_q  <= accept & pix_sof & (state_q == S_ACTIVE);
      case (state_q)
        S_DONE: begin
          state_q     <= S_IDLE;
          pix_ready_q <= 1'b1;
        end
        default: begin
          pix_ready_q <= 1'b1;
          if (process) begin
            wr_addr_q <= addr_d;
            din_q     <= sum_d;
            row_sum_q <= rs_d;
            if (last_px) begin
              state_q     <= S_DONE;
              pix_ready_q <= 1'b0;
              done_q      <= 1'b1;
              col_q       <= '0;
              row_q       <= '0;
              addr_q      <= '0;
            end else begin
              state_q <= S_ACTIVE;
              col_q   <= (col_d == COL_LAST) ? '0 : col_d + 1'b1;
              row_q   <= (col_d == COL_LAST) ? row_d + 1'b1 : row_d;
              addr_q  <= addr_d + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Line buffer holds the previous row's integral values; read above precedes this write.
  always_ff @(posedge clk) begin
    if (process) lb[col_d] <= sum_d;
  end

  assign pix_ready  = pix_ready_q;
  assign we         = we_q;
  assign wr_addr    = wr_addr_q;
  assign din        = din_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_integral_image_writer.sv
// Directed-vector bench for integral_image_writer: small 4x3 frames, full default frame, 10-bit overflow.
module tb_integral_image_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 4x3, 22-bit
  logic        valid_a = 0, sof_a = 0, ready_a, we_a, done_a, err_a;
  logic [7:0]  data_a = 0;
  logic [17:0] addr_a;
  logic [21:0] din_a;
  integral_image_writer #(.IMG_W(4), .IMG_H(3)) dut_a (
    .clk(clk), .rst(rst), .pix_valid(valid_a), .pix_data(data_a), .pix_sof(sof_a),
    .pix_ready(ready_a), .we(we_a), .wr_addr(addr_a), .din(din_a),
    .frame_done(done_a), .frame_err(err_a));

  // DUT B: default geometry
  logic        valid_b = 0, sof_b = 0, ready_b, we_b, done_b, err_b;
  logic [7:0]  data_b = 0;
  logic [17:0] addr_b;
  logic [21:0] din_b;
  integral_image_writer dut_b (
    .clk(clk), .rst(rst), .pix_valid(valid_b), .pix_data(data_b), .pix_sof(sof_b),
    .pix_ready(ready_b), .we(we_b), .wr_addr(addr_b), .din(din_b),
    .frame_done(done_b), .frame_err(err_b));

  // DUT C: 4x4, 10-bit words
  logic        valid_c = 0, sof_c = 0, ready_c, we_c, done_c, err_c;
  logic [7:0]  data_c = 0;
  logic [17:0] addr_c;
  logic [9:0]  din_c;
  integral_image_writer #(.IMG_W(4), .IMG_H(4), .DATA_WIDTH(10)) dut_c (
    .clk(clk), .rst(rst), .pix_valid(valid_c), .pix_data(data_c), .pix_sof(sof_c),
    .pix_ready(ready_c), .we(we_c), .wr_addr(addr_c), .din(din_c),
    .frame_done(done_c), .frame_err(err_c));

  typedef struct {
    logic       rst, valid, sof;
    logic [7:0] data;
    logic       we;
    int         addr, din;
    logic       done, err, ready;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void push(logic r, logic v, logic s, logic [7:0] d, logic w,
                               int a, int dn, logic fd, logic fe, logic rdy);
    vec_t x;
    x.rst = r; x.valid = v; x.sof = s; x.data = d; x.we = w;
    x.addr = a; x.din = dn; x.done = fd; x.err = fe; x.ready = rdy;
    tbl.push_back(x);
  endfunction

  // One frame of uniform pixel p on the 4x3 DUT: word k = p*(r+1)*(c+1)
  function automatic void push_frame(logic [7:0] p, bit toggle, bit err_first);
    for (int k = 0; k < 12; k++) begin
      push(0, 1, k == 0, p, 1, k, p * (k / 4 + 1) * (k % 4 + 1), k == 11,
           err_first && k == 0, k != 11);
      if (toggle) push(0, 0, 0, 0, 0, k, p * (k / 4 + 1) * (k % 4 + 1), 0, 0, 1);
    end
  endfunction

  task automatic chk(string name, longint got, longint want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int ofs;
    // reset state, then release
    push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // all-ones frame, continuous valid, then one idle cycle
    push_frame(1, 0, 0);
    push(0, 0, 0, 0, 0, 11, 12, 0, 0, 1);
    // same frame with valid toggling
    push_frame(1, 1, 0);
    // sof again at pixel 6 aborts, new frame completes
    for (int k = 0; k < 6; k++)
      push(0, 1, k == 0, 1, 1, k, (k / 4 + 1) * (k % 4 + 1), 0, 0, 1);
    push_frame(1, 0, 1);
    push(0, 0, 0, 0, 0, 11, 12, 0, 0, 1);
    // pixels without sof in IDLE are dropped
    for (int k = 0; k < 3; k++) push(0, 1, 0, 9, 0, 11, 12, 0, 0, 1);
    // partial frame of 2s, reset on pixel 5, drop non-sof pixel, then full frame of 2s
    for (int k = 0; k < 5; k++)
      push(0, 1, k == 0, 2, 1, k, 2 * (k / 4 + 1) * (k % 4 + 1), 0, 0, 1);
    push(1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push(0, 1, 0, 2, 0, 0, 0, 0, 0, 1);
    push_frame(2, 0, 0);
    push(0, 0, 0, 0, 0, 11, 24, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; valid_a = tbl[i].valid; sof_a = tbl[i].sof; data_a = tbl[i].data;
      @(posedge clk); #1;
      n_vec++;
      if (we_a !== tbl[i].we || addr_a !== 18'(tbl[i].addr) || din_a !== 22'(tbl[i].din) ||
          done_a !== tbl[i].done || err_a !== tbl[i].err || ready_a !== tbl[i].ready) begin
        n_bad++;
        $display("FAIL vec%0d: got we=%b addr=%0d din=%0d done=%b err=%b rdy=%b, want we=%b addr=%0d din=%0d done=%b err=%b rdy=%b",
                 i, we_a, addr_a, din_a, done_a, err_a, ready_a, tbl[i].we, tbl[i].addr,
                 tbl[i].din, tbl[i].done, tbl[i].err, tbl[i].ready);
      end
    end
    rst = 0; valid_a = 0; sof_a = 0;

    // full default frame of 255
    chk("b_ready_idle", ready_b, 1);
    for (int k = 0; k < 16384; k++) begin
      valid_b = 1; sof_b = (k == 0); data_b = 8'd255;
      @(posedge clk); #1;
      if (k == 127) begin
        chk("b_addr127", addr_b, 127); chk("b_din127", din_b, 32640);
      end else if (k == 128) begin
        chk("b_addr128", addr_b, 128); chk("b_din128", din_b, 510);
      end else if (k == 16383) begin
        chk("b_addr_last", addr_b, 16383); chk("b_din_last", din_b, 4177920);
        chk("b_done_last", {we_b, done_b}, 2'b11);
      end
    end
    valid_b = 0; sof_b = 0;
    @(posedge clk); #1;
    chk("b_we_after", {we_b, done_b, ready_b}, 3'b001);

    // 4x4 frame of 255 into 10-bit words
    for (int k = 0; k < 16; k++) begin
      valid_c = 1; sof_c = (k == 0); data_c = 8'd255;
      @(posedge clk); #1;
      if (k == 3) chk("c_din3", din_c, 1020);
`ifdef INTEGRAL_SAT_EN
      if (k == 7) chk("c_din7", din_c, 1023);
      if (k == 15) chk("c_din15", din_c, 1023);
`else
      if (k == 7) chk("c_din7", din_c, 1016);
      if (k == 15) chk("c_din15", din_c, 1008);
`endif
      if (k == 15) chk("c_done", {we_c, done_c, addr_c}, {2'b11, 18'd15});
    end
    valid_c = 0; sof_c = 0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
